exception_sequencer: RTL and testbench

Collects the exception flags produced along the pipeline, including the trap flag from EX, the overflow flag, decode faults, address errors and interrupts. It picks the oldest one, writes the CP0 exception state (EPC, Cause.ExcCode, Cause.BD, BadVAddr, Status.EXL), flushes the pipeline and redirects fetch to the exception vector with a handshake. It sits between the pipeline stage registers and CP0, and is the consumer of every per-stage exception-detect output.

---
 rtl/mips_exc_pkg.sv | 35 +++
 rtl/exception_sequencer_if.sv | 68 ++++++
 rtl/exception_priority.sv | 86 ++++++++
 rtl/exception_sequencer.sv | 146 ++++++++++++++
 tb/tb_exception_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_exc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mips_exc_pkg                                               |
// | Purpose  : Shared ExcCodes, sequencer states and default vectors.     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package mips_exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam logic [31:0] VEC_NORMAL_DEFAULT = 32'h8000_0180;
  localparam logic [31:0] VEC_BOOT_DEFAULT   = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_VECTOR = 2'd2
  } exc_state_e;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_from(input logic [31:0] pc, input logic isbds);
    return isbds ? (pc - 32'd4) : pc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exception_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : exception_sequencer_if                                     |
// | Purpose  : Pipeline exception flags in, CP0 update and redirect out.  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface exception_sequencer_if;

  logic        IF_AdEL;
  logic [31:0] IF_PC;
  logic        IF_IsBDS;
  logic        ID_RI;
  logic        ID_CpU;
  logic        ID_Sys;
  logic        ID_Bp;
  logic [31:0] ID_PC;
  logic        ID_IsBDS;
  logic        EX_Ov;
  logic        EX_Tr;
  logic [31:0] EX_PC;
  logic        EX_IsBDS;
  logic        M_AdEL;
  logic        M_AdES;
  logic [31:0] M_Addr;
  logic [31:0] M_PC;
  logic        M_IsBDS;
  logic        IntReq;
  logic        IE;
  logic        EXL;
  logic        ERL;
  logic        BEV;
  logic        M_Stall;
  logic        PCAck;

  logic [3:0]  Flush;
  logic        PCRedirect;
  logic [31:0] ExcVector;
  logic        CP0Write;
  logic [31:0] EPC;
  logic [4:0]  ExcCode;
  logic        BD;
  logic        BadVAddrWrite;
  logic [31:0] BadVAddr;
  logic        Busy;

  modport master (
    output IF_AdEL, IF_PC, IF_IsBDS,
    output ID_RI, ID_CpU, ID_Sys, ID_Bp, ID_PC, ID_IsBDS,
    output EX_Ov, EX_Tr, EX_PC, EX_IsBDS,
    output M_AdEL, M_AdES, M_Addr, M_PC, M_IsBDS,
    output IntReq, IE, EXL, ERL, BEV, M_Stall, PCAck,
    input  Flush, PCRedirect, ExcVector, CP0Write, EPC, ExcCode, BD,
    input  BadVAddrWrite, BadVAddr, Busy
  );

  modport slave (
    input  IF_AdEL, IF_PC, IF_IsBDS,
    input  ID_RI, ID_CpU, ID_Sys, ID_Bp, ID_PC, ID_IsBDS,
    input  EX_Ov, EX_Tr, EX_PC, EX_IsBDS,
    input  M_AdEL, M_AdES, M_Addr, M_PC, M_IsBDS,
    input  IntReq, IE, EXL, ERL, BEV, M_Stall, PCAck,
    output Flush, PCRedirect, ExcVector, CP0Write, EPC, ExcCode, BD,
    output BadVAddrWrite, BadVAddr, Busy
  );

endinterface
`default_nettype wire

// File: rtl/exception_priority.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : exception_priority                                         |
// | Purpose  : Combinational oldest-first exception selector.             |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module exception_priority
  import mips_exc_pkg::*;
(
  input  wire logic        i_if_adel,
  input  wire logic [31:0] i_if_pc,
  input  wire logic        i_if_isbds,
  input  wire logic        i_id_ri,
  input  wire logic        i_id_cpu,
  input  wire logic        i_id_sys,
  input  wire logic        i_id_bp,
  input  wire logic [31:0] i_id_pc,
  input  wire logic        i_id_isbds,
  input  wire logic        i_ex_ov,
  input  wire logic        i_ex_tr,
  input  wire logic [31:0] i_ex_pc,
  input  wire logic        i_ex_isbds,
  input  wire logic        i_m_adel,
  input  wire logic        i_m_ades,
  input  wire logic [31:0] i_m_addr,
  input  wire logic [31:0] i_m_pc,
  input  wire logic        i_m_isbds,
  input  wire logic        i_int_req,
  input  wire logic        i_ie,
  input  wire logic        i_exl,
  input  wire logic        i_erl,
  output logic             o_valid,
  output logic [4:0]       o_code,
  output logic [31:0]      o_pc,
  output logic             o_isbds,
  output logic [31:0]      o_badvaddr,
  output logic             o_has_badvaddr
);

  logic w_int_take;

  assign w_int_take = i_int_req & i_ie & ~i_exl & ~i_erl;

  // Interrupts ride on the M-stage instruction, so they rank just below M faults.
  always_comb begin
    o_valid        = 1'b1;
    o_code         = EXC_INT;
    o_pc           = i_m_pc;
    o_isbds        = i_m_isbds;
    o_badvaddr     = 32'd0;
    o_has_badvaddr = 1'b0;
    if (i_m_adel) begin
      o_code         = EXC_ADEL;
      o_badvaddr     = i_m_addr;
      o_has_badvaddr = 1'b1;
    end else if (i_m_ades) begin
      o_code         = EXC_ADES;
      o_badvaddr     = i_m_addr;
      o_has_badvaddr = 1'b1;
    end else if (w_int_take) begin
      o_code = EXC_INT;
    end else if (i_ex_ov || i_ex_tr) begin
      o_code  = i_ex_ov ? EXC_OV : EXC_TR;
      o_pc    = i_ex_pc;
      o_isbds = i_ex_isbds;
    end else if (i_id_ri || i_id_cpu || i_id_sys || i_id_bp) begin
      o_pc    = i_id_pc;
      o_isbds = i_id_isbds;
      if (i_id_ri)       o_code = EXC_RI;
      else if (i_id_cpu) o_code = EXC_CPU;
      else if (i_id_sys) o_code = EXC_SYS;
      else               o_code = EXC_BP;
    end else if (i_if_adel) begin
      o_code         = EXC_ADEL;
      o_pc           = i_if_pc;
      o_isbds        = i_if_isbds;
      o_badvaddr     = i_if_pc;
      o_has_badvaddr = 1'b1;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exception_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : exception_sequencer                                        |
// | Purpose  : Captures the oldest exception, updates CP0, flushes and    |
// |            redirects fetch to the exception vector.                   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module exception_sequencer
  import mips_exc_pkg::*;
#(
  parameter logic [31:0] VEC_NORMAL = VEC_NORMAL_DEFAULT,
  parameter logic [31:0] VEC_BOOT   = VEC_BOOT_DEFAULT
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  exception_sequencer_if.slave bus
);

  logic        w_valid;
  logic [4:0]  w_code;
  logic [31:0] w_pc;
  logic        w_isbds;
  logic [31:0] w_badvaddr;
  logic        w_has_badvaddr;

  exc_state_e  r_state;
  logic [3:0]  r_flush;
  logic        r_cp0write;
  logic        r_bvwrite;
  logic        r_redirect;
  logic [31:0] r_vector;
  logic [31:0] r_epc;
  logic [4:0]  r_code;
  logic        r_bd;
  logic [31:0] r_badvaddr;
  logic        r_bev;
  logic        r_busy;

  exception_priority u_priority (
    .i_if_adel      (bus.IF_AdEL),
    .i_if_pc        (bus.IF_PC),
    .i_if_isbds     (bus.IF_IsBDS),
    .i_id_ri        (bus.ID_RI),
    .i_id_cpu       (bus.ID_CpU),
    .i_id_sys       (bus.ID_Sys),
    .i_id_bp        (bus.ID_Bp),
    .i_id_pc        (bus.ID_PC),
    .i_id_isbds     (bus.ID_IsBDS),
    .i_ex_ov        (bus.EX_Ov),
    .i_ex_tr        (bus.EX_Tr),
    .i_ex_pc        (bus.EX_PC),
    .i_ex_isbds     (bus.EX_IsBDS),
    .i_m_adel       (bus.M_AdEL),
    .i_m_ades       (bus.M_AdES),
    .i_m_addr       (bus.M_Addr),
    .i_m_pc         (bus.M_PC),
    .i_m_isbds      (bus.M_IsBDS),
    .i_int_req      (bus.IntReq),
    .i_ie           (bus.IE),
    .i_exl          (bus.EXL),
    .i_erl          (bus.ERL),
    .o_valid        (w_valid),
    .o_code         (w_code),
    .o_pc           (w_pc),
    .o_isbds        (w_isbds),
    .o_badvaddr     (w_badvaddr),
    .o_has_badvaddr (w_has_badvaddr)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_flush    <= 4'd0;
      r_cp0write <= 1'b0;
      r_bvwrite  <= 1'b0;
      r_redirect <= 1'b0;
      r_vector   <= 32'd0;
      r_epc      <= 32'd0;
      r_code     <= 5'd0;
      r_bd       <= 1'b0;
      r_badvaddr <= 32'd0;
      r_bev      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid && !bus.M_Stall) begin
            r_state    <= ST_FLUSH;
            r_flush    <= 4'hF;
            r_cp0write <= 1'b1;
            r_bvwrite  <= w_has_badvaddr;
            r_code     <= w_code;
            r_bev      <= bus.BEV;
            r_busy     <= 1'b1;
            // Nested exception: keep the EPC/BD of the handler already running.
            if (!bus.EXL) begin
              r_epc <= epc_from(w_pc, w_isbds);
              r_bd  <= w_isbds;
            end
            if (w_has_badvaddr) begin
              r_badvaddr <= w_badvaddr;
            end
          end
        end
        ST_FLUSH: begin
          r_state    <= ST_VECTOR;
          r_flush    <= 4'd0;
          r_cp0write <= 1'b0;
          r_bvwrite  <= 1'b0;
          r_redirect <= 1'b1;
          r_vector   <= r_bev ? VEC_BOOT : VEC_NORMAL;
        end
        ST_VECTOR: begin
          if (bus.PCAck) begin
            r_state    <= ST_IDLE;
            r_redirect <= 1'b0;
            r_vector   <= 32'd0;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_flush    <= 4'd0;
          r_cp0write <= 1'b0;
          r_bvwrite  <= 1'b0;
          r_redirect <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Flush         = r_flush;
  assign bus.PCRedirect    = r_redirect;
  assign bus.ExcVector     = r_vector;
  assign bus.CP0Write      = r_cp0write;
  assign bus.EPC           = r_epc;
  assign bus.ExcCode       = r_code;
  assign bus.BD            = r_bd;
  assign bus.BadVAddrWrite = r_bvwrite;
  assign bus.BadVAddr      = r_badvaddr;
  assign bus.Busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_exception_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_exception_sequencer                                     |
// | Purpose  : Vector table, directed corner cases and random stimulus.   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_exception_sequencer;

  localparam logic [31:0] VN = 32'h8000_0180;
  localparam logic [31:0] VB = 32'hBFC0_0380;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  exception_sequencer_if ifc ();

  exception_sequencer #(.VEC_NORMAL(VN), .VEC_BOOT(VB)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifc.slave)
  );

  // req bits: 9 M_AdEL, 8 M_AdES, 7 IntReq, 6 EX_Ov, 5 EX_Tr, 4 ID_RI, 3 ID_CpU, 2 ID_Sys, 1 ID_Bp, 0 IF_AdEL
  // bds bits: {M, EX, ID, IF}; stage PCs are M=pc_m, EX=+4, ID=+8, IF=+12
  typedef struct {
    logic [9:0]  req;
    logic [3:0]  bds;
    logic [31:0] pc_m;
    logic [31:0] addr;
    logic        ie, exl, erl, bev;
    logic        take;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd, bvw;
    logic [31:0] badv;
    logic [31:0] vec;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [9:0] req, input logic [3:0] bds, input logic [31:0] pc_m,
                         input logic [31:0] addr, input logic ie, input logic exl,
                         input logic erl, input logic bev);
    ifc.M_AdEL = req[9]; ifc.M_AdES = req[8]; ifc.IntReq = req[7];
    ifc.EX_Ov  = req[6]; ifc.EX_Tr  = req[5];
    ifc.ID_RI  = req[4]; ifc.ID_CpU = req[3]; ifc.ID_Sys = req[2]; ifc.ID_Bp = req[1];
    ifc.IF_AdEL = req[0];
    ifc.M_PC  = pc_m;        ifc.EX_PC = pc_m + 32'd4;
    ifc.ID_PC = pc_m + 32'd8; ifc.IF_PC = pc_m + 32'd12;
    ifc.M_IsBDS = bds[3]; ifc.EX_IsBDS = bds[2]; ifc.ID_IsBDS = bds[1]; ifc.IF_IsBDS = bds[0];
    ifc.M_Addr = addr;
    ifc.IE = ie; ifc.EXL = exl; ifc.ERL = erl; ifc.BEV = bev;
  endtask

  task automatic drive_idle();
    set_req(10'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ifc.M_Stall = 1'b0;
    ifc.PCAck   = 1'b0;
  endtask

  task automatic drive_junk();
    set_req(10'($urandom), 4'($urandom), $urandom, $urandom,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    ifc.M_Stall = 1'($urandom);
  endtask

  // Reference: scan requests oldest-first and derive the CP0 update from the winner.
  task automatic ref_pick(input logic [9:0] req, input logic [3:0] bds, input logic [31:0] pc_m,
                          input logic [31:0] addr, input logic ie, input logic exl, input logic erl,
                          output logic take, output logic [4:0] code, output logic [31:0] epc,
                          output logic bd, output logic has_bv, output logic [31:0] badv);
    int codes[10] = '{4, 5, 0, 12, 13, 10, 11, 8, 9, 4};
    int stage[10] = '{3, 3, 3, 2, 2, 1, 1, 1, 1, 0};
    logic [9:0]  q;
    logic [31:0] pc;
    q    = req;
    q[7] = req[7] & ie & ~exl & ~erl;
    take = 1'b0; code = 5'd0; epc = 32'd0; bd = 1'b0; has_bv = 1'b0; badv = 32'd0;
    for (int i = 0; i < 10; i++) begin
      if (!take && q[9-i]) begin
        take   = 1'b1;
        code   = 5'(codes[i]);
        pc     = pc_m + 32'(4 * (3 - stage[i]));
        bd     = bds[stage[i]];
        epc    = bd ? pc - 32'd4 : pc;
        has_bv = (stage[i] == 3 && i < 2) || stage[i] == 0;
        badv   = (stage[i] == 0) ? pc : addr;
      end
    end
  endtask

  // Called at the negedge of the FLUSH cycle; returns at the negedge after the redirect drops.
  task automatic expect_exc(input string tag, input logic [4:0] code, input logic [31:0] epc,
                            input logic bd, input logic bvw, input logic [31:0] badv,
                            input logic [31:0] vec, input int ack_delay, input bit junk);
    chk({tag, "/flush"},   32'(ifc.Flush), 32'hF);
    chk({tag, "/cp0w"},    32'(ifc.CP0Write), 32'd1);
    chk({tag, "/bvw"},     32'(ifc.BadVAddrWrite), 32'(bvw));
    chk({tag, "/code"},    32'(ifc.ExcCode), 32'(code));
    chk({tag, "/epc"},     ifc.EPC, epc);
    chk({tag, "/bd"},      32'(ifc.BD), 32'(bd));
    if (bvw) chk({tag, "/badv"}, ifc.BadVAddr, badv);
    chk({tag, "/busy"},    32'(ifc.Busy), 32'd1);
    chk({tag, "/redir0"},  32'(ifc.PCRedirect), 32'd0);
    if (junk) drive_junk(); else drive_idle();
    ifc.PCAck = junk ? 1'($urandom) : 1'b0;
    for (int k = 0; k <= ack_delay; k++) begin
      @(negedge clk);
      chk({tag, "/redir"}, 32'(ifc.PCRedirect), 32'd1);
      chk({tag, "/vec"},   ifc.ExcVector, vec);
      chk({tag, "/pulse"}, 32'({ifc.Flush, ifc.CP0Write, ifc.BadVAddrWrite}), 32'd0);
      chk({tag, "/hold"},  32'(ifc.ExcCode), 32'(code));
      if (k == ack_delay) ifc.PCAck = 1'b1;
      else begin
        ifc.PCAck = 1'b0;
        if (junk) drive_junk();
      end
    end
    @(negedge clk);
    chk({tag, "/idle_redir"}, 32'(ifc.PCRedirect), 32'd0);
    chk({tag, "/idle_busy"},  32'(ifc.Busy), 32'd0);
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        take, bd, has_bv, stall;
    logic [4:0]  code;
    logic [31:0] epc, badv, pc_m;
    logic [9:0]  req;
    logic [3:0]  bds;
    logic        ie, exl, erl, bev;
    logic [31:0] addr;
    logic [31:0] m_epc, m_badv;
    logic [4:0]  m_code;
    logic        m_bd;
    logic [31:0] v0;

    tbl[0]  = '{10'h020, 4'h0, 32'h0040_000C, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 5'd13, 32'h0040_0010, 1'b0, 1'b0, 32'h0, VN};
    tbl[1]  = '{10'h144, 4'h8, 32'h0040_0024, 32'h1000_0003, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 5'd5, 32'h0040_0020, 1'b1, 1'b1, 32'h1000_0003, VN};
    tbl[2]  = '{10'h010, 4'h2, 32'h0050_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1,
                1'b1, 5'd10, 32'h0040_0020, 1'b1, 1'b0, 32'h0, VB};
    tbl[3]  = '{10'h080, 4'h0, 32'h0050_0100, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[4]  = '{10'h0C0, 4'h0, 32'h0060_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 5'd0, 32'h0060_0000, 1'b0, 1'b0, 32'h0, VN};
    tbl[5]  = '{10'h001, 4'h1, 32'h0070_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 5'd4, 32'h0070_0008, 1'b1, 1'b1, 32'h0070_000C, VN};
    tbl[6]  = '{10'h200, 4'h8, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b1, 5'd4, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0001, VB};
    tbl[7]  = '{10'h00A, 4'h0, 32'h0080_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 5'd11, 32'h0080_0008, 1'b0, 1'b0, 32'h0, VN};
    tbl[8]  = '{10'h082, 4'h0, 32'h0090_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 5'd9, 32'h0090_0008, 1'b0, 1'b0, 32'h0, VN};
    tbl[9]  = '{10'h060, 4'h4, 32'h00A0_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 5'd12, 32'h00A0_0000, 1'b1, 1'b0, 32'h0, VN};
    tbl[10] = '{10'h081, 4'h0, 32'h00B0_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0,
                1'b1, 5'd4, 32'h00B0_000C, 1'b0, 1'b1, 32'h00B0_000C, VN};

    drive_idle();
    repeat (2) @(negedge clk);
    chk("reset/outs", 32'({ifc.Flush, ifc.PCRedirect, ifc.CP0Write, ifc.BadVAddrWrite, ifc.Busy, ifc.BD}), 32'd0);
    chk("reset/epc", ifc.EPC, 32'd0);
    chk("reset/vec", ifc.ExcVector, 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      set_req(tbl[i].req, tbl[i].bds, tbl[i].pc_m, tbl[i].addr,
              tbl[i].ie, tbl[i].exl, tbl[i].erl, tbl[i].bev);
      @(negedge clk);
      if (tbl[i].take) begin
        expect_exc($sformatf("tbl%0d", i), tbl[i].code, tbl[i].epc, tbl[i].bd, tbl[i].bvw,
                   tbl[i].badv, tbl[i].vec, i % 3, 1'b0);
      end else begin
        chk($sformatf("tbl%0d/nocap", i), 32'({ifc.Flush, ifc.CP0Write, ifc.Busy}), 32'd0);
        drive_idle();
        @(negedge clk);
        chk($sformatf("tbl%0d/nocap2", i), 32'({ifc.Flush, ifc.CP0Write, ifc.Busy}), 32'd0);
      end
    end

    // Stall holds off capture; FLUSH lands one cycle after the stall drops.
    @(negedge clk);
    set_req(10'h040, 4'h0, 32'h0040_0100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    ifc.M_Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall/quiet", 32'({ifc.Flush, ifc.CP0Write, ifc.Busy}), 32'd0);
      if (k == 2) ifc.M_Stall = 1'b0;
    end
    @(negedge clk);
    expect_exc("stall", 5'd12, 32'h0040_0104, 1'b0, 1'b0, 32'h0, VN, 0, 1'b0);

    // Slow PCAck with ID_Bp pulsing underneath the redirect.
    set_req(10'h004, 4'h0, 32'h0040_0200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("hs/flush", 32'(ifc.Flush), 32'hF);
    chk("hs/code", 32'(ifc.ExcCode), 32'd8);
    chk("hs/epc", ifc.EPC, 32'h0040_0208);
    drive_idle();
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk("hs/redir", 32'(ifc.PCRedirect), 32'd1);
      chk("hs/vec", ifc.ExcVector, VN);
      chk("hs/nocap", 32'({ifc.CP0Write, ifc.ExcCode}), 32'({1'b0, 5'd8}));
      ifc.ID_Bp = (k % 2 == 0);
      if (k == 4) begin
        ifc.PCAck = 1'b1;
        ifc.ID_Bp = 1'b0;
      end
    end
    @(negedge clk);
    chk("hs/idle", 32'({ifc.PCRedirect, ifc.Busy}), 32'd0);
    ifc.PCAck = 1'b0;
    @(negedge clk);
    chk("hs/no_second", 32'({ifc.Flush, ifc.CP0Write, ifc.Busy}), 32'd0);

    // Reset asserted in the middle of VECTOR.
    set_req(10'h220, 4'h0, 32'h0040_0300, 32'h2000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    chk("rst/in_vector", 32'(ifc.PCRedirect), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst/outs", 32'({ifc.Flush, ifc.PCRedirect, ifc.CP0Write, ifc.BadVAddrWrite, ifc.Busy, ifc.BD}), 32'd0);
    chk("rst/regs", 32'(ifc.ExcCode) | ifc.EPC | ifc.BadVAddr | ifc.ExcVector, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst/after", 32'({ifc.PCRedirect, ifc.Busy}), 32'd0);
    end

    // Random phase against the reference; CP0 state starts from reset.
    m_epc = 32'd0; m_badv = 32'd0; m_code = 5'd0; m_bd = 1'b0;
    for (int it = 0; it < 300; it++) begin
      req = 10'd0;
      for (int b = 0; b < 10; b++) req[b] = ($urandom_range(0, 6) == 0);
      bds  = 4'($urandom);
      pc_m = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC);
      addr = $urandom;
      ie   = 1'($urandom);
      exl  = ($urandom_range(0, 3) == 0);
      erl  = ($urandom_range(0, 7) == 0);
      bev  = 1'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      set_req(req, bds, pc_m, addr, ie, exl, erl, bev);
      ifc.M_Stall = stall;
      ifc.PCAck   = 1'($urandom);
      ref_pick(req, bds, pc_m, addr, ie, exl, erl, take, code, epc, bd, has_bv, badv);
      @(negedge clk);
      if (take && !stall) begin
        m_code = code;
        if (!exl) begin
          m_epc = epc;
          m_bd  = bd;
        end
        if (has_bv) m_badv = badv;
        v0 = bev ? VB : VN;
        expect_exc($sformatf("rnd%0d", it), m_code, m_epc, m_bd, has_bv, m_badv, v0,
                   $urandom_range(0, 3), 1'b1);
      end else begin
        chk($sformatf("rnd%0d/nocap", it), 32'({ifc.Flush, ifc.CP0Write, ifc.Busy}), 32'd0);
        chk($sformatf("rnd%0d/hold", it), ifc.EPC ^ m_epc, 32'd0);
        chk($sformatf("rnd%0d/holdc", it), 32'({ifc.ExcCode, ifc.BD}), 32'({m_code, m_bd}));
        chk($sformatf("rnd%0d/holdb", it), ifc.BadVAddr, m_badv);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
